// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang board painter: colours, stone kinds,
// painter states and the 8x8 stone-shape mask.
package gobang_pkg;

  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CELL_W = 4;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned PIX_W  = 3;

  localparam logic [RGB_W-1:0] C_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] C_WHITE = 12'hFFF;
  localparam logic [RGB_W-1:0] C_BOARD = 12'hC94;

  localparam logic [KIND_W-1:0] K_ERASE   = 2'b00;
  localparam logic [KIND_W-1:0] K_BLACK   = 2'b01;
  localparam logic [KIND_W-1:0] K_WHITE   = 2'b10;
  localparam logic [KIND_W-1:0] K_ILLEGAL = 2'b11;

  localparam logic [CELL_W-1:0] CELL_MAX = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DRAW,
    S_DONE
  } state_t;

  // Stone footprint: the 8x8 square minus its four corner pixels.
  function automatic logic stone_mask(input logic [PIX_W-1:0] r, input logic [PIX_W-1:0] c);
    return !((r == 3'd0 || r == 3'd7) && (c == 3'd0 || c == 3'd7));
  endfunction

  function automatic logic [RGB_W-1:0] kind_colour(input logic [KIND_W-1:0] k);
    case (k)
      K_BLACK: return C_BLACK;
      K_WHITE: return C_WHITE;
      default: return C_BOARD;
    endcase
  endfunction

endpackage

// File: rtl/stone_painter.sv
// Paints (or erases) one gobang stone into the frame buffer: 8x8 pixels,
// corners skipped, placed inside the grid lines of the requested cell.
module stone_painter
  import gobang_pkg::*;
#(
  parameter int unsigned DW    = 15,
  parameter int unsigned H_RES = 200,
  parameter int unsigned X0    = 25,
  parameter int unsigned Y0    = 0,
  parameter int unsigned CELL  = 10
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              req,
  input  logic [3:0]        x_cell,
  input  logic [3:0]        y_cell,
  input  logic [1:0]        kind,
  output logic              ready,
  output logic              we,
  output logic [DW-1:0]     waddr,
  output logic [11:0]       wdata,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_n;
  logic [PIX_W-1:0]    row_q, row_n, col_q, col_n;
  logic [CELL_W-1:0]   x_q, x_n, y_q, y_n;
  logic [KIND_W-1:0]   kind_q, kind_n;
  logic [DW-1:0]       base_q, base_n, base_c, pix_base;
  logic                ready_n, we_n, done_n, err_n;
  logic [DW-1:0]       waddr_n;
  logic [RGB_W-1:0]    wdata_n;

  // State, counters, latches and registered outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      kind_q  <= '0;
      base_q  <= '0;
      ready   <= 1'b1;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      x_q     <= x_n;
      y_q     <= y_n;
      kind_q  <= kind_n;
      base_q  <= base_n;
      ready   <= ready_n;
      we      <= we_n;
      waddr   <= waddr_n;
      wdata   <= wdata_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  // Top-left pixel of the stone: one pixel inside the cell's grid lines.
  assign base_c = (DW'(Y0) + DW'(y_q) * DW'(CELL) + DW'(1)) * DW'(H_RES)
                + DW'(X0) + DW'(x_q) * DW'(CELL) + DW'(1);

  // Next-state logic; outputs are derived from the next pixel so they
  // line up with the state they describe once registered.
  always_comb begin
    state_n  = state_q;
    row_n    = row_q;
    col_n    = col_q;
    x_n      = x_q;
    y_n      = y_q;
    kind_n   = kind_q;
    base_n   = base_q;
    err_n    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (x_cell > CELL_MAX || y_cell > CELL_MAX || kind == K_ILLEGAL) begin
            err_n = 1'b1;
          end else begin
            x_n     = x_cell;
            y_n     = y_cell;
            kind_n  = kind;
            state_n = S_CALC;
          end
        end
      end
      S_CALC: begin
        base_n  = base_c;
        row_n   = '0;
        col_n   = '0;
        state_n = S_DRAW;
      end
      S_DRAW: begin
        col_n = col_q + 3'd1;
        if (col_q == 3'd7) begin
          row_n = row_q + 3'd1;
          if (row_q == 3'd7) state_n = S_DONE;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    pix_base = (state_q == S_CALC) ? base_c : base_q;
    ready_n  = (state_n == S_IDLE);
    done_n   = (state_n == S_DONE);
    we_n     = (state_n == S_DRAW) && stone_mask(row_n, col_n);
    waddr_n  = (state_n == S_DRAW) ? pix_base + DW'(row_n) * DW'(H_RES) + DW'(col_n) : '0;
    wdata_n  = (state_n == S_DRAW) ? kind_colour(kind_n) : '0;
  end

endmodule
